// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer in front of the 32-bit ALU.
// Decodes alu_op/funct into the ALU control code, pulses alu_start once,
// waits (bounded) for alu_finished and holds the captured response under
// a valid/ready handshake. Only one operation is ever in flight.
module alu_issue_ctrl #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_alu_op,
   input  logic [5:0]           in_funct,
   input  logic [WORD_SIZE-1:0] in_a,
   input  logic [WORD_SIZE-1:0] in_b,
   output logic                 alu_start,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   output logic [3:0]           alu_control,
   input  logic                 alu_finished,
   input  logic [WORD_SIZE-1:0] alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   input  logic                 alu_invalid,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_result,
   output logic                 out_zero,
   output logic                 out_overflow,
   output logic [1:0]           out_err
);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DECODE  = 2'b01;
   localparam logic [1:0] ERR_INVALID = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // Counter value on the last permitted WAIT cycle; reaching it without
   // alu_finished means the ALU has taken TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_start;
   logic [WORD_SIZE-1:0] r_a;
   logic [WORD_SIZE-1:0] r_b;
   logic [3:0]           r_ctrl;
   logic [WORD_SIZE-1:0] r_result;
   logic                 r_zero;
   logic                 r_ovf;
   logic [1:0]           r_err;
   logic                 r_out_valid;
   logic [7:0]           r_cnt;

   logic [3:0]           w_ctrl;
   logic                 w_dec_ok;

   // Translate alu_op/funct into the ALU control code; flag anything unknown.
   always_comb begin
      w_ctrl   = 4'hF;
      w_dec_ok = 1'b1;
      case (in_alu_op)
         2'b00: w_ctrl = 4'h2;
         2'b01: w_ctrl = 4'h6;
         2'b10: begin
            case (in_funct)
               6'b100000: w_ctrl = 4'h2;
               6'b100001: w_ctrl = 4'h3;
               6'b100010: w_ctrl = 4'h6;
               6'b100100: w_ctrl = 4'h0;
               6'b100101: w_ctrl = 4'h1;
               6'b100111: w_ctrl = 4'hC;
               6'b101010: w_ctrl = 4'h7;
               default:   w_dec_ok = 1'b0;
            endcase
         end
         default: w_dec_ok = 1'b0;
      endcase
   end

   // Sequencer: accept -> issue start pulse -> wait for ALU -> hold response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_start     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= 4'h0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= ERR_OK;
         r_out_valid <= 1'b0;
         r_cnt       <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a    <= in_a;
                  r_b    <= in_b;
                  r_ctrl <= w_ctrl;
                  if (w_dec_ok) begin
                     r_start <= 1'b1;
                     r_state <= ST_ISSUE;
                  end else begin
                     // Undecodable request: answer directly, ALU untouched.
                     r_result    <= '0;
                     r_zero      <= 1'b0;
                     r_ovf       <= 1'b0;
                     r_err       <= ERR_DECODE;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_ISSUE: begin
               r_start <= 1'b0;
               r_cnt   <= 8'd0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_finished) begin
                  r_result    <= alu_result;
                  r_zero      <= alu_zero;
                  r_ovf       <= alu_overflow;
                  r_err       <= alu_invalid ? ERR_INVALID : ERR_OK;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_result    <= '0;
                  r_zero      <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_err       <= ERR_TIMEOUT;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == ST_IDLE);
   assign alu_start    = r_start;
   assign alu_a        = r_a;
   assign alu_b        = r_b;
   assign alu_control  = r_ctrl;
   assign out_valid    = r_out_valid;
   assign out_result   = r_result;
   assign out_zero     = r_zero;
   assign out_overflow = r_ovf;
   assign out_err      = r_err;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer directly upstream of the 32-bit ALU (alu_32).
- Accepts a decoded operation (alu_op plus funct and two operands) over a valid/ready handshake, and translates it to the ALU 4-bit control code.
- Drives the ALU start pulse, waits for finished, then captures result/zero/overflow/invalid-control into a registered output held under valid/ready until consumed.
- Serialises ALU use: one operation in flight.

Parameters:
- WORD_SIZE, 32, operand/result width.
- TIMEOUT_CYCLES, 8, max WAIT cycles for alu_finished before aborting (range 1..255).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_alu_op  input  2  00=ADD, 01=SUB, 10=R-type (use funct), 11=reserved.
- in_funct  input  6  MIPS funct field.
- in_a  input  WORD_SIZE  operand A.
- in_b  input  WORD_SIZE  operand B.
- alu_start  output  1  ALU start (ALU acts on its rising edge).
- alu_a  output  WORD_SIZE  registered operand A to the ALU.
- alu_b  output  WORD_SIZE  registered operand B to the ALU.
- alu_control  output  4  registered control code to the ALU.
- alu_finished  input  1  ALU finished.
- alu_result  input  WORD_SIZE  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU err_overflow.
- alu_invalid  input  1  ALU err_invalid_control.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts the response.
- out_result  output  WORD_SIZE  captured result.
- out_zero  output  1  captured zero flag.
- out_overflow  output  1  captured overflow flag.
- out_err  output  2  00=ok, 01=decode error, 10=ALU invalid control, 11=timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0: state=IDLE; alu_start=0; alu_a, alu_b, alu_control, out_result=0; out_valid, out_zero, out_overflow=0; out_err=00; timeout counter=0.
- Decode (combinational on inputs, registered at accept):
  - alu_op 00 -> 4'h2; 01 -> 4'h6.
  - alu_op 10 with funct: 100000 -> 2 (ADD), 100001 -> 3 (ADDU), 100010 -> 6 (SUB), 100100 -> 0 (AND), 100101 -> 1 (OR), 100111 -> C (NOR), 101010 -> 7 (SLT).
  - Any other funct, or alu_op 11, is a decode error.
- in_ready=1 only in IDLE. A request is accepted on a rising edge with in_valid & in_ready.
- States:
  - IDLE: on accept, latch alu_a, alu_b and alu_control.
    - Valid decode: go to ISSUE.
    - Decode error: go to DONE with out_result=0, zero=0, ovf=0, err=01. alu_start is not pulsed.
  - ISSUE: alu_start=1 for exactly one cycle; counter cleared. Next state is WAIT.
  - WAIT: alu_start=0.
    - alu_finished=1 sampled: capture alu_result to out_result, alu_zero to out_zero, alu_overflow to out_overflow. err=10 if alu_invalid=1, else 00. Go to DONE.
    - Otherwise increment the counter. When counter reaches TIMEOUT_CYCLES: result=0, zero=0, ovf=0, err=11, go to DONE.
  - DONE: out_valid=1; all out_* held stable. On out_valid & out_ready, clear out_valid and go to IDLE.
- in_ready is not asserted in the same cycle as the DONE handshake. Minimum one-cycle IDLE gap, so alu_start is low for at least 3 cycles between pulses.
- Latency: accept at edge N, start high in cycle N..N+1, capture at edge N+2, out_valid high from N+2. Back-to-back throughput is 1 op per 4 cycles with out_ready held 1.
- alu_a, alu_b and alu_control are stable from ISSUE through WAIT. The ALU samples them on the start rising edge.
- Reset mid-operation (any state): immediate return to reset values; alu_start drops asynchronously; any in-flight result is discarded.
- Input changes while not in IDLE are ignored.
- out_valid stall: the block stays in DONE indefinitely; no new request is accepted.

Test Plan:
- alu_op=10, funct=100000, a=7, b=5, out_ready=1 -> one alu_start pulse; alu_control=2; out_result=12, zero=0, err=00; out_valid exactly 1 cycle.
- alu_op=01, a=5, b=5 -> alu_control=6; out_result=0, out_zero=1. Then funct=101010, a=3, b=9 -> control 7, out_result=1.
- alu_op=10, a=32'h7FFFFFFF, b=1 (ADD) -> out_overflow=1, result 32'h80000000, err=00.
- alu_op=11 -> no alu_start pulse; out_err=01, out_result=0. Separately, alu_finished tied 0 with TIMEOUT_CYCLES=8 -> out_err=11 exactly 8 WAIT cycles after ISSUE.
- out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout; release -> one handshake, next request accepted one cycle later.
- rst_n asserted during WAIT -> alu_start=0, out_valid=0 immediately. After release, a new ADD 1+1 -> result 2.
